fpu_core: RTL and testbench
===========================

Name: fpu_core

Overview:
- Single-precision (IEEE-754 binary32) floating-point execute unit for the cop1 path of the multi-cycle CPU core.
- Merges three functions into one registered block:
  - the cop1 arithmetic/move unit, which decodes opcode, fmt and funct fields;
  - a float equality comparator, which drives fbne;
  - a float less-than comparator, which drives fbg.
- All outputs are registered with 1-cycle latency. The core samples results in its execute state.

Parameters:
- OP_COP1, default 6'b010001: opcode value that selects the cop1 group.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands and instruction fields are valid this cycle.
- op  in  6  instruction opcode [31:26].
- fmt  in  5  cop1 fmt/rs field [25:21].
- funct  in  6  instruction funct [5:0].
- src_a  in  32  float operand A (float register fs).
- src_b  in  32  operand B: integer register rt for mtc1, otherwise float register ft.
- cmp_x  in  32  comparator left operand.
- cmp_y  in  32  comparator right operand.
- out_valid  out  1  registered copy of in_valid.
- result  out  32  operation result.
- exception  out  4  {nan_inf_in, underflow, overflow, illegal}.
- feq  out  1  cmp_x == cmp_y, as float.
- flt  out  1  cmp_x < cmp_y, as float.

Behaviour:
- Reset: when rst=1 at a clock edge, all outputs clear to 0. This includes a reset that arrives mid-operation; the pending result is discarded.
- Capture: each cycle with in_valid=1, all outputs update on the next edge from that cycle's inputs.
- Hold: with in_valid=0, result, exception, feq and flt hold their values and out_valid goes to 0.
- Decode when op==OP_COP1:
  - fmt=5'b00000 (mfc1): result=src_a, raw bits.
  - fmt=5'b00100 (mtc1): result=src_b, raw bits.
  - fmt=5'b10000: select by funct.
    - 000000 add: A+B.
    - 000001 sub: A−B.
    - 000010 mul: A×B.
    - 000101 abs: A with sign bit cleared.
    - 000111 neg: A with sign bit flipped.
    - 001001 mov: result=src_a.
    - Any other funct: result=0 and exception[0]=1.
  - Any other fmt: result=0, exception[0]=1.
- op≠OP_COP1: result=0 and exception=0. The comparators still operate.
- Arithmetic rules:
  - Round to nearest, ties to even.
  - Subnormal inputs are treated as signed zero.
  - Subnormal or too-small results flush to zero with the correct sign and set exception[2].
  - Exponent overflow returns ±infinity (exp=255, mantissa=0) and sets exception[1].
  - An operand with exp=255 (inf/NaN) sets exception[3]; the result is then canonical NaN 32'h7FC00000.
  - Exact cancellation in add/sub returns +0.
  - abs, neg, mov, mfc1 and mtc1 never set flags.
- Comparators (purely on cmp_x/cmp_y, independent of op):
  - feq=1 if the bit patterns are equal, or both are zero (+0 == −0). If either operand is NaN, feq=0.
  - flt=1 if cmp_x < cmp_y numerically.
    - Signs differ: negative < positive, except ±0 vs ±0 gives 0.
    - Both positive: compare {exp,mant} unsigned.
    - Both negative: reverse that comparison.
    - A NaN operand gives flt=0.
- Arithmetic is combinational into one output register stage. There are no multi-cycle operations and no back-pressure.

Test Plan:
- Reset: drive inputs and assert rst with in_valid=1 → next edge result=0, exception=0, feq=0, flt=0, out_valid=0.
- Add: op=010001, fmt=10000, funct=000000, A=3F800000 (1.0), B=40000000 (2.0) → one cycle later result=40400000, exception=0, out_valid=1.
- Sub and mul:
  - sub 1.0−1.0 → result=00000000.
  - mul 40400000×C0000000 → result=C0C00000.
  - mul 7F000000×7F000000 → result=7F800000, exception[1]=1.
- Moves:
  - mtc1, fmt=00100, B=12345678 → result=12345678.
  - mfc1, fmt=00000, A=BF800000 → result=BF800000.
  - abs of BF800000 → 3F800000.
  - neg of 3F800000 → BF800000.
- Compare:
  - X=80000000, Y=00000000 → feq=1, flt=0.
  - X=BF800000, Y=3F800000 → flt=1, feq=0.
  - X=40000000, Y=40400000 → flt=1.
  - X=C0400000, Y=C0000000 → flt=1.
  - X=7FC00000, Y=7FC00000 → feq=0, flt=0.
- Illegal and hold:
  - fmt=10000, funct=111111 → exception=0001, result=0.
  - Then in_valid=0 → outputs hold, out_valid=0.

Source files
------------

// File: rtl/fpu_core.sv
// fpu_core: registered binary32 cop1 execute unit with float equality and less-than comparators
module fpu_core #(
  parameter logic [5:0] OP_COP1 = 6'b010001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [5:0]  op,
  input  logic [4:0]  fmt,
  input  logic [5:0]  funct,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] cmp_x,
  input  logic [31:0] cmp_y,
  output logic        out_valid,
  output logic [31:0] result,
  output logic [3:0]  exception,
  output logic        feq,
  output logic        flt
);
  function automatic logic [33:0] pack(input logic sign, input logic signed [10:0] base, input logic [50:0] s);
    logic [5:0] p;
    logic [50:0] n;
    logic [24:0] m;
    logic signed [10:0] e;
    logic inc;
    p = '0;
    for (int i = 0; i < 51; i++) if (s[i]) p = i[5:0];
    n = s << (6'd50 - p);
    inc = n[26] & ((|n[25:0]) | n[27]);
    m = {1'b0, n[50:27]} + {24'b0, inc};
    e = base - 11'sd50 + $signed({5'b0, p}) + $signed({10'b0, m[24]});
    if (e >= 11'sd255) return {2'b10, sign, 8'hff, 23'b0};
    if (e <= 11'sd0) return {2'b01, sign, 31'b0};
    return {2'b00, sign, e[7:0], m[24] ? m[23:1] : m[22:0]};
  endfunction
  logic [7:0] ea, eb, big_e, sml_e, d;
  logic [23:0] ma, mb, big_m, sml_m;
  logic sa, sb, big_s, a_big, special, nan_x, nan_y, both_z;
  logic [49:0] sml_ext, aligned;
  logic [50:0] add_s;
  logic [47:0] prod;
  logic [33:0] add_pk, mul_pk, ar;
  logic [31:0] res_n;
  logic [3:0] exc_n;
  logic feq_n, flt_n;
  assign ea = src_a[30:23];
  assign eb = src_b[30:23];
  assign ma = ea == 8'd0 ? 24'd0 : {1'b1, src_a[22:0]};
  assign mb = eb == 8'd0 ? 24'd0 : {1'b1, src_b[22:0]};
  assign sa = src_a[31];
  assign sb = src_b[31] ^ funct[0];
  assign special = ea == 8'hff || eb == 8'hff;
  assign a_big = {ea, ma} >= {eb, mb};
  assign big_e = a_big ? ea : eb;
  assign sml_e = a_big ? eb : ea;
  assign big_m = a_big ? ma : mb;
  assign sml_m = a_big ? mb : ma;
  assign big_s = a_big ? sa : sb;
  assign d = big_e - sml_e;
  assign sml_ext = {sml_m, 26'b0};
  assign aligned = (sml_ext >> d) | {49'b0, |(sml_ext & ~({50{1'b1}} << d))};
  assign add_s = sa != sb ? {1'b0, big_m, 26'b0} - {1'b0, aligned} : {1'b0, big_m, 26'b0} + {1'b0, aligned};
  assign add_pk = add_s == 51'd0 ? {2'b00, sa & sb, 31'b0} : pack(big_s, $signed({3'b0, big_e}) + 11'sd1, add_s);
  assign prod = {24'b0, ma} * {24'b0, mb};
  assign mul_pk = prod == 48'd0 ? {2'b00, sa ^ src_b[31], 31'b0}
                : pack(sa ^ src_b[31], $signed({3'b0, ea}) + $signed({3'b0, eb}) - 11'sd126, {prod, 3'b0});
  assign ar = funct[1] ? mul_pk : add_pk;
  always_comb begin
    res_n = '0;
    exc_n = '0;
    if (op == OP_COP1) begin
      if (fmt == 5'b00000) res_n = src_a;
      else if (fmt == 5'b00100) res_n = src_b;
      else if (fmt == 5'b10000) begin
        case (funct)
          6'b000000, 6'b000001, 6'b000010: begin
            res_n = special ? 32'h7fc00000 : ar[31:0];
            exc_n = special ? 4'b1000 : {1'b0, ar[32], ar[33], 1'b0};
          end
          6'b000101: res_n = {1'b0, src_a[30:0]};
          6'b000111: res_n = {~src_a[31], src_a[30:0]};
          6'b001001: res_n = src_a;
          default:   exc_n = 4'b0001;
        endcase
      end else exc_n = 4'b0001;
    end
  end
  assign nan_x = &cmp_x[30:23] && |cmp_x[22:0];
  assign nan_y = &cmp_y[30:23] && |cmp_y[22:0];
  assign both_z = ~|cmp_x[30:0] && ~|cmp_y[30:0];
  assign feq_n = !nan_x && !nan_y && (cmp_x == cmp_y || both_z);
  assign flt_n = nan_x || nan_y ? 1'b0
               : cmp_x[31] != cmp_y[31] ? cmp_x[31] & !both_z
               : cmp_x[31] ? cmp_x[30:0] > cmp_y[30:0] : cmp_x[30:0] < cmp_y[30:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result <= '0;
      exception <= '0;
      feq <= 1'b0;
      flt <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= res_n;
        exception <= exc_n;
        feq <= feq_n;
        flt <= flt_n;
      end
    end
  end
endmodule

// File: tb/tb_fpu_core.sv
// tb_fpu_core: directed scoreboard bench for fpu_core
module tb_fpu_core;
  localparam logic [5:0] C = 6'b010001;
  localparam logic [4:0] F = 5'b10000;
  typedef struct packed {
    logic v;
    logic [31:0] r;
    logic [3:0] e;
    logic q;
    logic l;
  } exp_t;
  logic clk, rst, in_valid, out_valid, feq, flt;
  logic [5:0] op, funct;
  logic [4:0] fmt;
  logic [31:0] src_a, src_b, cmp_x, cmp_y, result;
  logic [3:0] exception;
  exp_t sbq[$];
  exp_t last;
  int total, bad;
  fpu_core dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .fmt(fmt), .funct(funct),
    .src_a(src_a), .src_b(src_b), .cmp_x(cmp_x), .cmp_y(cmp_y),
    .out_valid(out_valid), .result(result), .exception(exception), .feq(feq), .flt(flt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask
  task automatic step(input string name, input logic r, input logic v, input logic [5:0] o,
                      input logic [4:0] f, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] x, input logic [31:0] y, input logic [31:0] er,
                      input logic [3:0] ee, input logic eq, input logic el);
    exp_t t, g;
    @(negedge clk);
    rst = r;
    in_valid = v;
    op = o;
    fmt = f;
    funct = fn;
    src_a = a;
    src_b = b;
    cmp_x = x;
    cmp_y = y;
    if (r) t = '0;
    else if (!v) begin
      t = last;
      t.v = 1'b0;
    end else begin
      t.v = 1'b1;
      t.r = er;
      t.e = ee;
      t.q = eq;
      t.l = el;
    end
    last = t;
    sbq.push_back(t);
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    chk({name, ".valid"}, {31'b0, out_valid}, {31'b0, g.v});
    chk({name, ".result"}, result, g.r);
    chk({name, ".exc"}, {28'b0, exception}, {28'b0, g.e});
    chk({name, ".feq"}, {31'b0, feq}, {31'b0, g.q});
    chk({name, ".flt"}, {31'b0, flt}, {31'b0, g.l});
  endtask
  initial begin
    total = 0;
    bad = 0;
    last = '0;
    rst = 1'b1;
    in_valid = 1'b0;
    op = '0;
    fmt = '0;
    funct = '0;
    src_a = '0;
    src_b = '0;
    cmp_x = '0;
    cmp_y = '0;
    repeat (2) @(posedge clk);
    step("reset",    1, 1, C, F, 6'o00, 32'h3F800000, 32'h40000000, 32'hBF800000, 32'h3F800000, 0, 0, 0, 0);
    step("add",      0, 1, C, F, 6'o00, 32'h3F800000, 32'h40000000, 0, 0, 32'h40400000, 4'b0000, 1, 0);
    step("sub_zero", 0, 1, C, F, 6'o01, 32'h3F800000, 32'h3F800000, 0, 0, 32'h00000000, 4'b0000, 1, 0);
    step("sub_neg",  0, 1, C, F, 6'o01, 32'h3F800000, 32'h40000000, 0, 0, 32'hBF800000, 4'b0000, 1, 0);
    step("mul",      0, 1, C, F, 6'o02, 32'h40400000, 32'hC0000000, 0, 0, 32'hC0C00000, 4'b0000, 1, 0);
    step("hold1",    0, 0, C, F, 6'o00, 32'h11111111, 32'h22222222, 32'hBF800000, 32'h3F800000, 0, 0, 0, 0);
    step("mul_ovf",  0, 1, C, F, 6'o02, 32'h7F000000, 32'h7F000000, 0, 0, 32'h7F800000, 4'b0010, 1, 0);
    step("mul_unf",  0, 1, C, F, 6'o02, 32'h00800000, 32'h80800000, 0, 0, 32'h80000000, 4'b0100, 1, 0);
    step("add_inf",  0, 1, C, F, 6'o00, 32'h7F800000, 32'h3F800000, 0, 0, 32'h7FC00000, 4'b1000, 1, 0);
    step("rne_even", 0, 1, C, F, 6'o00, 32'h3F800000, 32'h33800000, 0, 0, 32'h3F800000, 4'b0000, 1, 0);
    step("rne_up",   0, 1, C, F, 6'o00, 32'h3F800001, 32'h33800000, 0, 0, 32'h3F800002, 4'b0000, 1, 0);
    step("mtc1",     0, 1, C, 5'b00100, 6'o00, 32'hDEADBEEF, 32'h12345678, 0, 0, 32'h12345678, 4'b0000, 1, 0);
    step("mfc1",     0, 1, C, 5'b00000, 6'o00, 32'hBF800000, 32'h12345678, 0, 0, 32'hBF800000, 4'b0000, 1, 0);
    step("abs",      0, 1, C, F, 6'o05, 32'hBF800000, 32'h7F800000, 0, 0, 32'h3F800000, 4'b0000, 1, 0);
    step("neg",      0, 1, C, F, 6'o07, 32'h3F800000, 32'h7F800000, 0, 0, 32'hBF800000, 4'b0000, 1, 0);
    step("mov",      0, 1, C, F, 6'o11, 32'h40490FDB, 32'h7F800000, 0, 0, 32'h40490FDB, 4'b0000, 1, 0);
    step("cmp_z",    0, 1, 0, F, 6'o00, 32'h3F800000, 32'h3F800000, 32'h80000000, 32'h00000000, 0, 0, 1, 0);
    step("cmp_sgn",  0, 1, 0, F, 6'o00, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 0, 0, 0, 1);
    step("cmp_pos",  0, 1, 0, F, 6'o00, 0, 0, 32'h40000000, 32'h40400000, 0, 0, 0, 1);
    step("cmp_negs", 0, 1, 0, F, 6'o00, 0, 0, 32'hC0400000, 32'hC0000000, 0, 0, 0, 1);
    step("cmp_gt",   0, 1, 0, F, 6'o00, 0, 0, 32'h40400000, 32'h40000000, 0, 0, 0, 0);
    step("cmp_nan",  0, 1, 0, F, 6'o00, 0, 0, 32'h7FC00000, 32'h7FC00000, 0, 0, 0, 0);
    step("illegal",  0, 1, C, F, 6'o77, 32'h3F800000, 32'h3F800000, 0, 0, 32'h00000000, 4'b0001, 1, 0);
    step("hold2",    0, 0, C, F, 6'o00, 32'h3F800000, 32'h40000000, 32'hBF800000, 32'h3F800000, 0, 0, 0, 0);
    step("bad_fmt",  0, 1, C, 5'b00001, 6'o00, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 0, 4'b0001, 0, 1);
    step("rst_mid",  1, 1, C, F, 6'o02, 32'h40400000, 32'hC0000000, 32'h40000000, 32'h40000000, 0, 0, 0, 0);
    step("recover",  0, 1, C, F, 6'o00, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40400000, 4'b0000, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
